// File: rtl/ts_pkg.sv
// Shared types and constants for the transmit scheduler.
package ts_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWaitMd,
    StWaitDone
  } ts_state_e;

  // Queue indices
  localparam logic [1:0] Q_EVEN = 2'd0;
  localparam logic [1:0] Q_ODD  = 2'd1;
  localparam logic [1:0] Q_RSV  = 2'd2;
  localparam logic [1:0] Q_BE   = 2'd3;

  // Two maximum-size frames of credit
  localparam int unsigned CREDIT_MAX_DEF = 3036;

endpackage

// File: rtl/ts_credit.sv
// Saturating token bucket for the bandwidth-reserved queue. Latches the head packet length when
// queue 2 wins arbitration and charges it on the read pulse.
module ts_credit #(
  parameter int unsigned CREDIT_INC = 1,
  parameter int unsigned CREDIT_MAX = 3036,
  parameter int unsigned CREDIT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [10:0]         pkt_len_i,
  input  logic                sel_i,
  input  logic                dec_i,
  output logic                eligible_o,
  output logic [CREDIT_W-1:0] credit_o
);

  localparam logic [CREDIT_W:0] IncExt = (CREDIT_W + 1)'(CREDIT_INC);
  localparam logic [CREDIT_W:0] MaxExt = (CREDIT_W + 1)'(CREDIT_MAX);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [10:0]         len_q, len_d;
  logic [CREDIT_W:0]   sum;

  // Credit accrues every cycle, is charged once per queue-2 read, and saturates at the ceiling.
  // No underflow: selection required credit >= length and credit has only grown since.
  always_comb begin
    sum = {1'b0, credit_q} + IncExt - (dec_i ? (CREDIT_W + 1)'(len_q) : '0);
    credit_d = (sum > MaxExt) ? MaxExt[CREDIT_W-1:0] : sum[CREDIT_W-1:0];
    len_d = sel_i ? pkt_len_i : len_q;
  end

  // Bucket and latched length registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= '0;
      len_q    <= '0;
    end else begin
      credit_q <= credit_d;
      len_q    <= len_d;
    end
  end

  assign eligible_o = 32'(credit_q) >= 32'(pkt_len_i);
  assign credit_o   = credit_q;

endmodule

// File: rtl/ts_sched.sv
// Transmit scheduler: strict priority slot TSN > credit-gated reserved > best effort, with a
// single packet in flight. Optional macro CBS_EN builds the queue-2 token-bucket gate.
module ts_sched
  import ts_pkg::*;
#(
  parameter int unsigned CREDIT_INC = 1,
  parameter int unsigned CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int unsigned CREDIT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  in_ts_fifo_empty,
  input  logic [10:0] in_ts_pkt_len,
  input  logic        in_ts_slot_odd,
  output logic        out_ts_q0_rden,
  output logic        out_ts_q1_rden,
  output logic        out_ts_q2_rden,
  output logic        out_ts_q3_rden,
  input  logic [7:0]  in_ts_md,
  input  logic        in_ts_md_wr,
  output logic [7:0]  out_ts_md,
  output logic        out_ts_md_wr,
  output logic [1:0]  out_ts_qid,
  input  logic        in_ts_tx_done,
  output logic        out_ts_busy
);

  ts_state_e  state_q, state_d;
  logic [1:0] qid_q, qid_d;
  logic [7:0] md_q, md_d;
  logic       md_wr_q, md_wr_d;
  logic [1:0] oqid_q, oqid_d;
  logic [3:0] rden;
  logic       credit_ok;
  logic       win_vld;
  logic [1:0] win_qid;
  logic [1:0] slot_qid;

`ifdef CBS_EN
  logic [CREDIT_W-1:0] credit;

  ts_credit #(
    .CREDIT_INC (CREDIT_INC),
    .CREDIT_MAX (CREDIT_MAX),
    .CREDIT_W   (CREDIT_W)
  ) u_credit (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pkt_len_i  (in_ts_pkt_len),
    .sel_i      ((state_q == StIdle) && win_vld && (win_qid == Q_RSV)),
    .dec_i      ((state_q == StRead) && (qid_q == Q_RSV)),
    .eligible_o (credit_ok),
    .credit_o   (credit)
  );
`else
  // Without the bucket queue 2 is gated only by its empty flag
  localparam int unsigned unused_cfg = CREDIT_INC + CREDIT_MAX + CREDIT_W;
  logic unused_len;
  assign unused_len = ^in_ts_pkt_len;
  assign credit_ok  = 1'b1;
`endif

  assign slot_qid = in_ts_slot_odd ? Q_ODD : Q_EVEN;

  // Priority pick; the off-slot TSN queue is never considered
  always_comb begin
    win_vld = 1'b0;
    win_qid = Q_EVEN;
    if (!in_ts_fifo_empty[slot_qid]) begin
      win_vld = 1'b1;
      win_qid = slot_qid;
    end else if (!in_ts_fifo_empty[Q_RSV] && credit_ok) begin
      win_vld = 1'b1;
      win_qid = Q_RSV;
    end else if (!in_ts_fifo_empty[Q_BE]) begin
      win_vld = 1'b1;
      win_qid = Q_BE;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a missing metadata strobe still hands completion to the transmitter
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (win_vld) state_d = StRead;
      StRead:     state_d = StWaitMd;
      StWaitMd:   state_d = StWaitDone;
      StWaitDone: if (in_ts_tx_done) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath next values: winner latch and metadata capture
  always_comb begin
    qid_d   = qid_q;
    md_d    = md_q;
    md_wr_d = 1'b0;
    oqid_d  = oqid_q;
    if ((state_q == StIdle) && win_vld) begin
      qid_d = win_qid;
    end
    if ((state_q == StWaitMd) && in_ts_md_wr) begin
      md_d    = in_ts_md;
      md_wr_d = 1'b1;
      oqid_d  = qid_q;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qid_q   <= Q_EVEN;
      md_q    <= '0;
      md_wr_q <= 1'b0;
      oqid_q  <= Q_EVEN;
    end else begin
      qid_q   <= qid_d;
      md_q    <= md_d;
      md_wr_q <= md_wr_d;
      oqid_q  <= oqid_d;
    end
  end

  // Outputs: one read pulse for the latched winner while in StRead
  always_comb begin
    rden = '0;
    if (state_q == StRead) begin
      rden[qid_q] = 1'b1;
    end
  end

  assign out_ts_q0_rden = rden[0];
  assign out_ts_q1_rden = rden[1];
  assign out_ts_q2_rden = rden[2];
  assign out_ts_q3_rden = rden[3];
  assign out_ts_md      = md_q;
  assign out_ts_md_wr   = md_wr_q;
  assign out_ts_qid     = oqid_q;
  assign out_ts_busy    = (state_q != StIdle);

endmodule
